pipe_intr_mdu: RTL and testbench

Iterative multiply/divide unit for the interrupt-capable pipelined CPU, owning the HI/LO register pair. It executes MULT, MULTU, DIV and DIVU with a width-parametrised radix-2 datapath. It sits beside the combinational EX-stage ALU, and the pipeline stalls on `busy` when it needs HI/LO. A `cancel` input aborts an in-flight operation on an interrupt or exception flush without corrupting the architectural HI/LO.

---
 rtl/pipe_intr_mdu_pkg.sv | 24 ++
 rtl/pipe_intr_mdu_step.sv | 34 +++
 rtl/pipe_intr_mdu.sv | 144 ++++++++++++++
 tb/tb_pipe_intr_mdu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_intr_mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and small op-decoding helpers.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_signed(input logic [1:0] op_v);
    return (op_v == MDU_MULT) || (op_v == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op_v);
    return (op_v == MDU_DIV) || (op_v == MDU_DIVU);
  endfunction

endpackage

// File: rtl/pipe_intr_mdu_step.sv
// One radix-2 iteration on the {upper, lower} accumulator: shift-add for
// multiply, restoring subtract-compare for divide.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] diff_s;

  // Next accumulator value for the selected operation
  always_comb begin
    sum_s    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} +
               (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    rem_sh_s = acc_i[2*WIDTH-1:WIDTH-1];
    diff_s   = rem_sh_s - {1'b0, opnd_i};
    if (is_div_i) begin
      // diff_s[WIDTH] set means the trial subtraction went negative: restore
      if (!diff_s[WIDTH]) begin
        acc_o = {diff_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum_s, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/pipe_intr_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with flush cancel and
// MTHI/MTLO write ports. Latency is WIDTH+1 cycles for every operation.
module pipe_intr_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q;
  logic               rneg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;

  logic               a_neg_d;
  logic               b_neg_d;
  logic [WIDTH-1:0]   a_abs_d;
  logic [WIDTH-1:0]   b_abs_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   quot_d;
  logic [WIDTH-1:0]   rem_d;
  logic               div_zero_d;
  logic [WIDTH-1:0]   fix_hi_d;
  logic [WIDTH-1:0]   fix_lo_d;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_is_div(op_q)),
    .acc_i    (acc_q),
    .opnd_i   (b_q),
    .acc_o    (acc_d)
  );

  // Operand magnitudes at launch and sign-corrected results for FIX
  always_comb begin
    a_neg_d    = op_is_signed(op) & a[WIDTH-1];
    b_neg_d    = op_is_signed(op) & b[WIDTH-1];
    a_abs_d    = a_neg_d ? -a : a;
    b_abs_d    = b_neg_d ? -b : b;
    prod_d     = neg_q ? -acc_q : acc_q;
    quot_d     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_d      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    div_zero_d = (b_q == {WIDTH{1'b0}});
    // With a zero divisor the remainder path already reproduces the dividend
    if (op_is_div(op_q)) begin
      fix_hi_d = rem_d;
      fix_lo_d = div_zero_d ? {WIDTH{1'b1}} : quot_d;
    end else begin
      fix_hi_d = prod_d[2*WIDTH-1:WIDTH];
      fix_lo_d = prod_d[WIDTH-1:0];
    end
  end

  // Control FSM, iteration state and the architectural HI/LO/dz registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_hi) hi_q <= wdata;
      if (wr_lo) lo_q <= wdata;
      case (state_q)
        IDLE: begin
          if (start && !cancel) begin
            op_q    <= op;
            b_q     <= b_abs_d;
            acc_q   <= {{WIDTH{1'b0}}, a_abs_d};
            neg_q   <= a_neg_d ^ b_neg_d;
            rneg_q  <= a_neg_d;
            cnt_q   <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= FIX;
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (!cancel) begin
            hi_q   <= fix_hi_d;
            lo_q   <= fix_lo_d;
            done_q <= 1'b1;
            if (op_is_div(op_q)) dz_q <= div_zero_d;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_pipe_intr_mdu.sv
// Self-checking bench for pipe_intr_mdu: vector table plus random ops through a
// scoreboard, and hand-written cancel, MTHI/MTLO and reset sequences.
module tb_pipe_intr_mdu;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        clrn, start, cancel, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic dz_m;
  vec_t tbl[14];

  pipe_intr_mdu #(.WIDTH(32)) dut (
    .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] av,
                                 input logic [31:0] bv, input logic dzp);
    exp_t r;
    logic [63:0] p;
    int sa, sd;
    r.dz = dzp;
    r.hi = 32'd0;
    r.lo = 32'd0;
    case (o)
      2'd0: begin
        p = {{32{av[31]}}, av} * {{32{bv[31]}}, bv};
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      2'd1: begin
        p = {32'd0, av} * {32'd0, bv};
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      default: begin
        r.dz = (bv == 32'd0);
        if (bv == 32'd0) begin
          r.lo = 32'hFFFFFFFF; r.hi = av;
        end else if (o == 2'd2) begin
          if (av == 32'h80000000 && bv == 32'hFFFFFFFF) begin
            r.lo = av; r.hi = 32'd0;
          end else begin
            sa = av; sd = bv;
            r.lo = sa / sd; r.hi = sa % sd;
          end
        end else begin
          r.lo = av / bv; r.hi = av % bv;
        end
      end
    endcase
    return r;
  endfunction

  // Scoreboard: every done pulse is matched against the oldest expectation
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("hi", 64'(hi), 64'(mon_e.hi));
        check("lo", 64'(lo), 64'(mon_e.lo));
        check("dz", 64'(dz), 64'(mon_e.dz));
      end
    end
  end

  // Launch one op, optionally pulse MTHI/MTLO at cycle wr_at, and check latency
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input exp_t e, input int wr_at, input logic [1:0] wmask,
                        input logic [31:0] wval);
    int   n;
    logic seen, wr_pend;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    sb.push_back(e);
    dz_m = e.dz;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; seen = 1'b0; wr_pend = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #2;
      n++;
      if (wr_pend) begin
        wr_hi = 1'b0; wr_lo = 1'b0; wr_pend = 1'b0;
        if (n <= 32) begin
          if (wmask[0]) check("mtlo_busy", 64'(lo), 64'(wval));
          if (wmask[1]) check("mthi_busy", 64'(hi), 64'(wval));
          check("busy_mid", 64'(busy), 64'd1);
        end
      end
      if (done) seen = 1'b1;
      else if (n == wr_at) begin
        wr_lo = wmask[0]; wr_hi = wmask[1]; wdata = wval; wr_pend = 1'b1;
      end
    end
    check("latency", 64'(n), 64'd33);
    check("busy_in_done", 64'(busy), 64'd0);
  endtask

  initial begin
    exp_t e;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    clrn = 1'b0; start = 1'b0; cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'd0; a = 32'd0; b = 32'd0; wdata = 32'd0; dz_m = 1'b0;

    tbl[0]  = '{2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tbl[1]  = '{2'd1, 32'hFFFFFFFD, 32'd7,        32'h00000006, 32'hFFFFFFEB, 1'b0};
    tbl[2]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[3]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tbl[4]  = '{2'd2, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    tbl[5]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1};
    tbl[6]  = '{2'd3, 32'd9,        32'd3,        32'd0,        32'd3,        1'b0};
    tbl[7]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    tbl[8]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    tbl[9]  = '{2'd3, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    tbl[10] = '{2'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    tbl[11] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1};
    tbl[12] = '{2'd3, 32'd3,        32'd10,       32'd3,        32'd0,        1'b0};
    tbl[13] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    @(negedge clk);
    clrn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      e = '{tbl[i].hi, tbl[i].lo, tbl[i].dz};
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, e, 0, 2'b00, 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      run_op(ro, ra, rb, model(ro, ra, rb, dz_m), 0, 2'b00, 32'd0);
    end

    // MTHI while idle
    @(negedge clk);
    wr_hi = 1'b1; wdata = 32'hABCD;
    @(posedge clk);
    #2 wr_hi = 1'b0;
    check("mthi_idle", 64'(hi), 64'hABCD);

    // MTLO mid-operation, then the op result overwrites LO
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, '{32'd0, 32'h80000000, 1'b0}, 5, 2'b01, 32'h1234);
    // MTHI/MTLO landing on the FIX edge lose to the result write
    run_op(2'd3, 32'd100, 32'd7, '{32'd2, 32'd14, 1'b0}, 32, 2'b11, 32'hDEAD);

    // Cancel mid-operation leaves HI/LO/dz untouched and produces no done
    run_op(2'd1, 32'd2, 32'd3, '{32'd0, 32'd6, dz_m}, 0, 2'b00, 32'd0);
    @(negedge clk);
    op = 2'd0; a = 32'h80000000; b = 32'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("busy_before_cancel", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    check("busy_after_cancel", 64'(busy), 64'd0);
    repeat (40) @(posedge clk);
    #2;
    check("cancel_hi", 64'(hi), 64'd0);
    check("cancel_lo", 64'(lo), 64'd6);
    check("cancel_dz", 64'(dz), 64'(dz_m));

    // cancel together with start in IDLE: no launch
    @(negedge clk);
    op = 2'd3; a = 32'd9; b = 32'd3; start = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b0;
    check("cancel_start_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    check("cancel_start_busy_later", 64'(busy), 64'd0);

    // Reset in the middle of a DIV, then a normal op afterwards
    run_op(2'd2, 32'd5, 32'd0, '{32'd5, 32'hFFFFFFFF, 1'b1}, 0, 2'b00, 32'd0);
    @(negedge clk);
    op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("busy_before_reset", 64'(busy), 64'd1);
    clrn = 1'b0;
    #1;
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_dz", 64'(dz), 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    run_op(2'd3, 32'd9, 32'd3, '{32'd0, 32'd3, 1'b0}, 0, 2'b00, 32'd0);

    repeat (3) @(posedge clk);
    #2;
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
